// File: rtl/bias_relu_loader.sv
// bias_relu_loader
//
// Streams a C x H x W tensor of signed 16-bit activations out of word-addressed
// memory, adds one signed 16-bit bias per channel (saturating when SAT=1,
// wrapping when SAT=0), clamps negatives to zero and writes each result to the
// output tensor at the same element offset.
//
// Ports:
//   clk, rst_n              clock, asynchronous active-low reset
//   start                   one-cycle start pulse, only honoured while idle
//   C, H, W                 tensor dimensions (latched on start)
//   ifaddr, ofaddr, baddr   27-bit base word addresses (latched on start)
//   rvalid/raddr/rready/rdata   read request port (element in rdata[15:0])
//   wvalid/waddr/wdata/wready   write request port (wdata = {16'b0, result})
//   done                    one-cycle completion pulse
module bias_relu_loader #(
    parameter bit SAT = 1'b1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic [10:0] C,
    input  logic [10:0] H,
    input  logic [10:0] W,
    input  logic [26:0] ifaddr,
    input  logic [26:0] ofaddr,
    input  logic [26:0] baddr,
    output logic        rvalid,
    output logic [25:0] raddr,
    input  logic        rready,
    input  logic [31:0] rdata,
    output logic        wvalid,
    output logic [25:0] waddr,
    output logic [31:0] wdata,
    input  logic        wready,
    output logic        done
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LB,
        S_LD,
        S_ST,
        S_DONE
    } state_t;

    state_t      state_q, state_d;
    logic [10:0] c_q, c_d;
    logic [21:0] hw_q, hw_d;
    logic [26:0] ifaddr_q, ifaddr_d;
    logic [26:0] ofaddr_q, ofaddr_d;
    logic [26:0] baddr_q, baddr_d;
    logic [15:0] bias_q, bias_d;
    logic [25:0] off_q, off_d;
    logic [21:0] pix_q, pix_d;
    logic [10:0] ch_q, ch_d;
    logic        rvalid_q, rvalid_d;
    logic [25:0] raddr_q, raddr_d;
    logic        wvalid_q, wvalid_d;
    logic [25:0] waddr_q, waddr_d;
    logic [31:0] wdata_q, wdata_d;
    logic        done_q, done_d;

    // Only the low half of a read word carries the element.
    logic unused_rdata_hi;
    assign unused_rdata_hi = ^rdata[31:16];

    // Base + index at 27 bits, then keep the low 26 bits; wrap is legal.
    function automatic logic [25:0] addr26(input logic [26:0] base, input logic [25:0] idx);
        logic [26:0] s;
        s = base + {1'b0, idx};
        return s[25:0];
    endfunction

    // Bias add with optional saturation, followed by ReLU.
    logic [16:0] sum17;
    logic [15:0] sum16;
    logic [15:0] relu16;

    always_comb begin
        sum17 = {rdata[15], rdata[15:0]} + {bias_q[15], bias_q};
        // Overflow shows up as the two top bits of the 17-bit sum disagreeing.
        if (SAT && (sum17[16] != sum17[15])) begin
            sum16 = sum17[16] ? 16'h8000 : 16'h7FFF;
        end else begin
            sum16 = sum17[15:0];
        end
        relu16 = sum16[15] ? 16'h0000 : sum16;
    end

    logic pix_wrap;
    logic last_elem;

    assign pix_wrap  = ((pix_q + 22'd1) == hw_q);
    assign last_elem = pix_wrap && (ch_q == (c_q - 11'd1));

    always_comb begin
        state_d  = state_q;
        c_d      = c_q;
        hw_d     = hw_q;
        ifaddr_d = ifaddr_q;
        ofaddr_d = ofaddr_q;
        baddr_d  = baddr_q;
        bias_d   = bias_q;
        off_d    = off_q;
        pix_d    = pix_q;
        ch_d     = ch_q;
        rvalid_d = rvalid_q;
        raddr_d  = raddr_q;
        wvalid_d = wvalid_q;
        waddr_d  = waddr_q;
        wdata_d  = wdata_q;
        done_d   = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    c_d      = C;
                    // Plane size computed once per run; per-element stepping is pure counting.
                    hw_d     = {11'd0, H} * {11'd0, W};
                    ifaddr_d = ifaddr;
                    ofaddr_d = ofaddr;
                    baddr_d  = baddr;
                    off_d    = '0;
                    pix_d    = '0;
                    ch_d     = '0;
                    if ((C == 11'd0) || (H == 11'd0) || (W == 11'd0)) begin
                        state_d = S_DONE;
                        done_d  = 1'b1;
                    end else begin
                        state_d  = S_LB;
                        rvalid_d = 1'b1;
                        raddr_d  = baddr[25:0];
                    end
                end
            end
            S_LB: begin
                if (rready) begin
                    bias_d  = rdata[15:0];
                    state_d = S_LD;
                    raddr_d = addr26(ifaddr_q, off_q);
                end
            end
            S_LD: begin
                if (rready) begin
                    rvalid_d = 1'b0;
                    wvalid_d = 1'b1;
                    waddr_d  = addr26(ofaddr_q, off_q);
                    wdata_d  = {16'd0, relu16};
                    state_d  = S_ST;
                end
            end
            S_ST: begin
                if (wready) begin
                    wvalid_d = 1'b0;
                    off_d    = off_q + 26'd1;
                    pix_d    = pix_q + 22'd1;
                    if (last_elem) begin
                        state_d = S_DONE;
                        done_d  = 1'b1;
                    end else if (pix_wrap) begin
                        ch_d     = ch_q + 11'd1;
                        pix_d    = '0;
                        state_d  = S_LB;
                        rvalid_d = 1'b1;
                        raddr_d  = addr26(baddr_q, {15'd0, ch_q + 11'd1});
                    end else begin
                        state_d  = S_LD;
                        rvalid_d = 1'b1;
                        raddr_d  = addr26(ifaddr_q, off_q + 26'd1);
                    end
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            c_q      <= '0;
            hw_q     <= '0;
            ifaddr_q <= '0;
            ofaddr_q <= '0;
            baddr_q  <= '0;
            bias_q   <= '0;
            off_q    <= '0;
            pix_q    <= '0;
            ch_q     <= '0;
            rvalid_q <= 1'b0;
            raddr_q  <= '0;
            wvalid_q <= 1'b0;
            waddr_q  <= '0;
            wdata_q  <= '0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            c_q      <= c_d;
            hw_q     <= hw_d;
            ifaddr_q <= ifaddr_d;
            ofaddr_q <= ofaddr_d;
            baddr_q  <= baddr_d;
            bias_q   <= bias_d;
            off_q    <= off_d;
            pix_q    <= pix_d;
            ch_q     <= ch_d;
            rvalid_q <= rvalid_d;
            raddr_q  <= raddr_d;
            wvalid_q <= wvalid_d;
            waddr_q  <= waddr_d;
            wdata_q  <= wdata_d;
            done_q   <= done_d;
        end
    end

    assign rvalid = rvalid_q;
    assign raddr  = raddr_q;
    assign wvalid = wvalid_q;
    assign waddr  = waddr_q;
    assign wdata  = wdata_q;
    assign done   = done_q;

endmodule

// File: tb/tb_bias_relu_loader.sv
// Testbench for bias_relu_loader: two instances (SAT=1 and SAT=0) share a
// memory responder; expected reads/writes are queued before each run and
// popped as the selected instance handshakes.
module tb_bias_relu_loader;

    logic        clk;
    logic        rst_n;
    logic        start_r;
    logic        sel;
    logic [10:0] c_in, h_in, w_in;
    logic [26:0] ia_in, oa_in, ba_in;
    logic        rready, wready;
    logic [31:0] rdata;

    logic        rvalid_a, wvalid_a, done_a, rvalid_b, wvalid_b, done_b;
    logic [25:0] raddr_a, waddr_a, raddr_b, waddr_b;
    logic [31:0] wdata_a, wdata_b;
    logic        start_a, start_b;

    assign start_a = start_r & ~sel;
    assign start_b = start_r & sel;

    bias_relu_loader #(.SAT(1'b1)) u_sat (
        .clk(clk), .rst_n(rst_n), .start(start_a),
        .C(c_in), .H(h_in), .W(w_in),
        .ifaddr(ia_in), .ofaddr(oa_in), .baddr(ba_in),
        .rvalid(rvalid_a), .raddr(raddr_a), .rready(rready), .rdata(rdata),
        .wvalid(wvalid_a), .waddr(waddr_a), .wdata(wdata_a), .wready(wready),
        .done(done_a)
    );

    bias_relu_loader #(.SAT(1'b0)) u_wrap (
        .clk(clk), .rst_n(rst_n), .start(start_b),
        .C(c_in), .H(h_in), .W(w_in),
        .ifaddr(ia_in), .ofaddr(oa_in), .baddr(ba_in),
        .rvalid(rvalid_b), .raddr(raddr_b), .rready(rready), .rdata(rdata),
        .wvalid(wvalid_b), .waddr(waddr_b), .wdata(wdata_b), .wready(wready),
        .done(done_b)
    );

    logic        rvalid_m, wvalid_m, done_m;
    logic [25:0] raddr_m, waddr_m;
    logic [31:0] wdata_m;
    assign rvalid_m = sel ? rvalid_b : rvalid_a;
    assign wvalid_m = sel ? wvalid_b : wvalid_a;
    assign done_m   = sel ? done_b   : done_a;
    assign raddr_m  = sel ? raddr_b  : raddr_a;
    assign waddr_m  = sel ? waddr_b  : waddr_a;
    assign wdata_m  = sel ? wdata_b  : wdata_a;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [25:0] addr;
        logic [31:0] data;
    } wr_t;

    typedef struct {
        logic [15:0] bias;
        logic [15:0] x;
        logic [15:0] exp_sat;
        logic [15:0] exp_wrap;
    } sat_vec_t;

    logic [31:0] mem [0:1023];
    logic [25:0] exp_rq[$];
    wr_t         exp_wq[$];

    int errors = 0;
    int checks = 0;
    int c0 = 0;
    int done_cnt, done_cyc, first_r, first_w, nreads, nwrites, valid_cycles;
    bit bp_mode = 1'b0;

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, got, exp, $time);
        end
    endtask

    function automatic logic [25:0] a26(input logic [26:0] b, input int e);
        logic [31:0] s;
        s = 32'(b) + 32'(e);
        return s[25:0];
    endfunction

    task automatic push_wr(input logic [25:0] a, input logic [15:0] d);
        wr_t t;
        t.addr = a;
        t.data = {16'd0, d};
        exp_wq.push_back(t);
    endtask

    // Memory responder and protocol monitor, active on the falling edge.
    int          rwait = 0, wwait = 0;
    bit          r_pend = 1'b0, w_pend = 1'b0;
    logic [25:0] r_hold, w_hold;
    logic [31:0] wd_hold;
    initial begin
        rready = 1'b0;
        wready = 1'b0;
        rdata  = '0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                r_pend = 1'b0;
                w_pend = 1'b0;
                rready = 1'b0;
                wready = 1'b0;
                continue;
            end
            if (done_m) begin
                done_cnt++;
                done_cyc = cyc;
            end
            if (rvalid_m || wvalid_m) begin
                valid_cycles++;
                chk("rw_exclusive", {63'd0, rvalid_m & wvalid_m}, 64'd0);
            end
            if (rvalid_m && first_r < 0) first_r = cyc - c0;
            if (wvalid_m && first_w < 0) first_w = cyc - c0;

            // read side
            if (r_pend) begin
                chk("rvalid_hold", {63'd0, rvalid_m}, 64'd1);
                chk("raddr_hold", {38'd0, raddr_m}, {38'd0, r_hold});
            end
            if (rvalid_m) begin
                if (bp_mode && rwait > 0) begin
                    rready = 1'b0;
                    rwait--;
                end else begin
                    rready = 1'b1;
                end
                rdata = mem[raddr_m[9:0]];
            end else begin
                rready = bp_mode ? 1'($urandom_range(0, 1)) : 1'b1;
                rdata  = $urandom;
            end
            if (rvalid_m && rready) begin
                nreads++;
                if (exp_rq.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL rd_unexpected: got read at %0h expected none", raddr_m);
                end else begin
                    logic [25:0] ea;
                    ea = exp_rq.pop_front();
                    chk("rd_addr", {38'd0, raddr_m}, {38'd0, ea});
                end
                rwait  = bp_mode ? $urandom_range(0, 5) : 0;
                r_pend = 1'b0;
            end else begin
                r_pend = rvalid_m;
                r_hold = raddr_m;
            end

            // write side
            if (w_pend) begin
                chk("wvalid_hold", {63'd0, wvalid_m}, 64'd1);
                chk("waddr_hold", {38'd0, waddr_m}, {38'd0, w_hold});
                chk("wdata_hold", {32'd0, wdata_m}, {32'd0, wd_hold});
            end
            if (wvalid_m) begin
                if (bp_mode && wwait > 0) begin
                    wready = 1'b0;
                    wwait--;
                end else begin
                    wready = 1'b1;
                end
            end else begin
                wready = bp_mode ? 1'($urandom_range(0, 1)) : 1'b1;
            end
            if (wvalid_m && wready) begin
                nwrites++;
                if (exp_wq.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL wr_unexpected: got write %0h at %0h expected none", wdata_m, waddr_m);
                end else begin
                    wr_t ew;
                    ew = exp_wq.pop_front();
                    chk("wr_addr", {38'd0, waddr_m}, {38'd0, ew.addr});
                    chk("wr_data", {32'd0, wdata_m}, {32'd0, ew.data});
                    $display("write addr=%0h data=%0h expected addr=%0h data=%0h",
                             waddr_m, wdata_m, ew.addr, ew.data);
                end
                wwait  = bp_mode ? $urandom_range(0, 5) : 0;
                w_pend = 1'b0;
            end else begin
                w_pend  = wvalid_m;
                w_hold  = waddr_m;
                wd_hold = wdata_m;
            end
        end
    end

    task automatic setup(input bit use_wrap, input logic [10:0] c, input logic [10:0] h,
                         input logic [10:0] w, input logic [26:0] ia, input logic [26:0] oa,
                         input logic [26:0] ba);
        sel   = use_wrap;
        c_in  = c;
        h_in  = h;
        w_in  = w;
        ia_in = ia;
        oa_in = oa;
        ba_in = ba;
        done_cnt = 0;
        first_r = -1;
        first_w = -1;
        nreads = 0;
        nwrites = 0;
        valid_cycles = 0;
    endtask

    // Issues start, waits for done (bounded), then checks pulse count and queues.
    task automatic run_op(input int exp_done, input bit extra_starts);
        bit seen;
        @(negedge clk);
        #1;
        start_r = 1'b1;
        c0 = cyc;
        @(negedge clk);
        #1;
        start_r = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 3000; i++) begin
            if (done_cnt > 0) begin
                seen = 1'b1;
                break;
            end
            @(negedge clk);
            #1;
            start_r = extra_starts && (i == 3 || i == 7);
        end
        start_r = 1'b0;
        chk("done_seen", {63'd0, seen}, 64'd1);
        if (exp_done >= 0) chk("done_cycle", 64'(done_cyc - c0), 64'(exp_done));
        repeat (4) @(negedge clk);
        #1;
        chk("done_pulses", 64'(done_cnt), 64'd1);
        chk("rd_left", 64'(exp_rq.size()), 64'd0);
        chk("wr_left", 64'(exp_wq.size()), 64'd0);
    endtask

    logic [15:0] bx [4];
    logic [15:0] bexp [4];

    task automatic load_basic(input logic [26:0] ia, input logic [26:0] oa, input logic [26:0] ba);
        logic [25:0] a;
        a = a26(ba, 0);
        mem[a[9:0]] = 32'hBEEF_0000;
        exp_rq.push_back(a);
        for (int e = 0; e < 4; e++) begin
            a = a26(ia, e);
            mem[a[9:0]] = {16'hABCD, bx[e]};
            exp_rq.push_back(a);
            push_wr(a26(oa, e), bexp[e]);
        end
    endtask

    sat_vec_t tbl [10];

    initial begin
        bx   = '{16'd5, 16'hFFFD, 16'd0, 16'h7FFF};
        bexp = '{16'd5, 16'd0, 16'd0, 16'h7FFF};
        tbl[0] = '{16'h7FFF, 16'h0001, 16'h7FFF, 16'h0000};
        tbl[1] = '{16'h8000, 16'hFFFF, 16'h0000, 16'h7FFF};
        tbl[2] = '{16'h0010, 16'hFFF0, 16'h0000, 16'h0000};
        tbl[3] = '{16'h0005, 16'h0003, 16'h0008, 16'h0008};
        tbl[4] = '{16'hFFFE, 16'h0001, 16'h0000, 16'h0000};
        tbl[5] = '{16'h4000, 16'h4000, 16'h7FFF, 16'h0000};
        tbl[6] = '{16'h7FFF, 16'h7FFF, 16'h7FFF, 16'h0000};
        tbl[7] = '{16'h8000, 16'h8000, 16'h0000, 16'h0000};
        tbl[8] = '{16'h0100, 16'h0123, 16'h0223, 16'h0223};
        tbl[9] = '{16'hC000, 16'h7FFF, 16'h3FFF, 16'h3FFF};
        for (int i = 0; i < 1024; i++) mem[i] = 32'hDEAD_0000 | 32'(i);

        start_r = 1'b0;
        setup(1'b0, 11'd1, 11'd1, 11'd1, 27'd200, 27'd600, 27'd100);

        // reset state
        rst_n = 1'b0;
        #12;
        chk("rst_rvalid", {63'd0, rvalid_a}, 64'd0);
        chk("rst_wvalid", {63'd0, wvalid_a}, 64'd0);
        chk("rst_done", {63'd0, done_a}, 64'd0);
        chk("rst_raddr", {38'd0, raddr_a}, 64'd0);
        chk("rst_waddr", {38'd0, waddr_a}, 64'd0);
        chk("rst_wdata", {32'd0, wdata_a}, 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // basic ReLU with timing
        setup(1'b0, 11'd1, 11'd2, 11'd2, 27'd200, 27'd600, 27'd100);
        load_basic(27'd200, 27'd600, 27'd100);
        run_op(10, 1'b0);
        chk("basic_first_rd", 64'(first_r), 64'd1);
        chk("basic_first_wr", 64'(first_w), 64'd3);

        // saturation table on both instances
        for (int j = 0; j < 2; j++) begin
            for (int k = 0; k < 10; k++) begin
                setup(j[0], 11'd1, 11'd1, 11'd1, 27'd200, 27'd600, 27'd100);
                mem[100] = {16'h1234, tbl[k].bias};
                mem[200] = {16'h5A5A, tbl[k].x};
                exp_rq.push_back(26'd100);
                exp_rq.push_back(26'd200);
                push_wr(26'd600, (j == 0) ? tbl[k].exp_sat : tbl[k].exp_wrap);
                run_op(4, 1'b0);
            end
        end

        // multi-channel, with stray start pulses mid-run
        setup(1'b0, 11'd3, 11'd1, 11'd2, 27'd300, 27'd700, 27'd50);
        mem[50] = 32'h0000_0001;
        mem[51] = 32'hFFFF_FFFF;
        mem[52] = 32'h0000_0064;
        for (int e = 0; e < 6; e++) mem[300 + e] = 32'h7777_000A;
        for (int c = 0; c < 3; c++) begin
            exp_rq.push_back(a26(27'd50, c));
            exp_rq.push_back(a26(27'd300, 2 * c));
            exp_rq.push_back(a26(27'd300, 2 * c + 1));
        end
        push_wr(26'd700, 16'd11);
        push_wr(26'd701, 16'd11);
        push_wr(26'd702, 16'd9);
        push_wr(26'd703, 16'd9);
        push_wr(26'd704, 16'd110);
        push_wr(26'd705, 16'd110);
        run_op(16, 1'b1);
        chk("multi_reads", 64'(nreads), 64'd9);

        // backpressure with addresses wrapping modulo 2^26
        bp_mode = 1'b1;
        setup(1'b0, 11'd1, 11'd2, 11'd2, 27'h3FF_FFFE, 27'h7FF_FFFE, 27'h400_0050);
        load_basic(27'h3FF_FFFE, 27'h7FF_FFFE, 27'h400_0050);
        run_op(-1, 1'b0);
        chk("bp_writes", 64'(nwrites), 64'd4);
        bp_mode = 1'b0;

        // degenerate dimensions
        setup(1'b0, 11'd4, 11'd0, 11'd3, 27'd200, 27'd600, 27'd100);
        run_op(1, 1'b0);
        chk("zero_h_valids", 64'(valid_cycles), 64'd0);
        setup(1'b1, 11'd0, 11'd5, 11'd5, 27'd200, 27'd600, 27'd100);
        run_op(1, 1'b0);
        chk("zero_c_valids", 64'(valid_cycles), 64'd0);

        // reset during element 2, then restart
        setup(1'b0, 11'd1, 11'd2, 11'd2, 27'd200, 27'd600, 27'd100);
        load_basic(27'd200, 27'd600, 27'd100);
        @(negedge clk);
        #1;
        start_r = 1'b1;
        @(negedge clk);
        #1;
        start_r = 1'b0;
        for (int i = 0; i < 100; i++) begin
            if (nwrites >= 1) break;
            @(negedge clk);
            #1;
        end
        chk("abort_first_write", 64'(nwrites), 64'd1);
        @(negedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        chk("abort_rvalid", {63'd0, rvalid_a}, 64'd0);
        chk("abort_wvalid", {63'd0, wvalid_a}, 64'd0);
        chk("abort_done", {63'd0, done_a}, 64'd0);
        chk("abort_raddr", {38'd0, raddr_a}, 64'd0);
        chk("abort_waddr", {38'd0, waddr_a}, 64'd0);
        chk("abort_wdata", {32'd0, wdata_a}, 64'd0);
        repeat (3) @(negedge clk);
        #1;
        exp_rq.delete();
        exp_wq.delete();
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        #1;
        chk("abort_no_done", 64'(done_cnt), 64'd0);
        setup(1'b0, 11'd1, 11'd2, 11'd2, 27'd200, 27'd600, 27'd100);
        load_basic(27'd200, 27'd600, 27'd100);
        run_op(10, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/bias_relu_loader.md
# bias_relu_loader

Per-channel bias-add and ReLU stage that runs directly upstream of the max-pool loader. It streams a C×H×W tensor of signed 16-bit activations from memory, adds one 16-bit bias per channel with saturation, clamps negatives to zero, and writes the result to an output tensor. That output tensor is the input feature map the max-pool stage consumes. It uses the same word-addressed read/write memory ports as the other loaders.

## Interface
- `SAT`, default 1: 1 means saturate the bias sum to int16; 0 means wrap (keep the low 16 bits).
- `clk`  in  1  rising-edge clock.
- `rst_n`  in  1  reset; asynchronous, active-low.
- `start`  in  1  single-cycle start pulse; sampled only in S_IDLE.
- `C`, `H`, `W`  in  11 each  tensor dimensions; latched on start.
- `ifaddr`  in  27  input tensor base word address; latched on start.
- `ofaddr`  in  27  output tensor base word address; latched on start.
- `baddr`  in  27  bias vector base word address; latched on start.
- `rvalid`  out  1  read request.
- `raddr`  out  26  read word address.
- `rready`  in  1  read complete; `rdata` is valid in this cycle.
- `rdata`  in  32  read data; the element is in `[15:0]`.
- `wvalid`  out  1  write request.
- `waddr`  out  26  write word address.
- `wdata`  out  32  write data, always `{16'b0, result}`.
- `wready`  in  1  write accepted.
- `done`  out  1  one-cycle completion pulse.

## Operation
- Element order is channel-major: for c, then h, then w. Element e sits at `ifaddr+e` and writes to `ofaddr+e`. The bias for channel c is at `baddr+c`.
- All addresses are computed at 27 bits and truncated to the low 26 bits. Wrap-around modulo 2^26 is legal and must not be flagged.
- Address generation uses counters, not multipliers:
  - element offset `off`, 26 bits;
  - in-plane index `pix`, 22 bits, wraps at H·W;
  - channel counter `ch`, 11 bits.
- The caller guarantees C·H·W ≤ 2^26.
- FSM states and transitions:
  - **S_IDLE**: outputs idle. On `start`, latch all inputs and clear the counters. If any of C, H, W is 0, go to S_DONE; otherwise go to S_LB.
  - **S_LB**: `rvalid=1`, `raddr=baddr+ch`. On `rready`, latch `rdata[15:0]` as `bias` and go to S_LD.
  - **S_LD**: `rvalid=1`, `raddr=ifaddr+off`. On `rready`, compute the result, load `wdata` and `waddr=ofaddr+off`, and go to S_ST.
  - **S_ST**: `wvalid=1`. On `wready`:
    - increment `off` and `pix`;
    - if this was the last element, go to S_DONE;
    - else if `pix` wrapped, increment `ch`, clear `pix`, and go to S_LB;
    - else go to S_LD.
  - **S_DONE**: `done=1` for exactly one cycle, then go to S_IDLE.
- Arithmetic:
  - `sum = sext17(x) + sext17(bias)`.
  - With SAT=1: clamp to [-32768, 32767]. With SAT=0: keep `sum[15:0]`.
  - `result = (result < 0) ? 0 : result`.
- `start` is ignored in every state other than S_IDLE.
- `rvalid` and `wvalid` are never high in the same cycle.

## Timing
- Reset (`rst_n` low, asynchronous): state S_IDLE; `rvalid`, `wvalid`, `done` = 0; `raddr`, `waddr`, `wdata` = 0; all counters and `bias` = 0. Asserting reset mid-operation aborts the operation; no partial `done` is produced.
- All outputs are registered.
- Request rule: once `rvalid` or `wvalid` is raised, it and its address/data stay stable until the cycle in which `rready`/`wready` is high. The request drops, or moves to the next address, in the following cycle.
- A ready seen without a matching valid is ignored.
- With ready held high, from `start` sampled in cycle T:
  - the bias read is issued at T+1;
  - the first element read is issued at T+2;
  - its write is issued at T+3.
  - Throughput: 2 cycles per element, plus 1 cycle per channel for the bias read.
- `done` asserts in the cycle after the final `wready`.
- Zero-dimension case: `done` asserts at T+1 with no memory access.
- A new `start` is accepted in the first S_IDLE cycle after `done`.

## Test plan
- **Basic ReLU.** C=1, H=2, W=2, bias[0]=0, data {5, −3, 0, 32767}, always ready. Required: writes {5, 0, 0, 32767} to ofaddr+0..3; `done` at T+10.
- **Saturation (SAT=1).**
  - bias=0x7FFF, x=1 → 0x7FFF.
  - bias=0x8000, x=−1 → 0.
  - bias=0x0010, x=0xFFF0 → 0.
  - Repeat with SAT=0: the first case writes 0, from the wrapped value 0x8000 clamped by ReLU.
- **Multi-channel.** C=3, H=1, W=2, biases {1, −1, 100}, data all 10. Required:
  - bias reads at baddr+0, 1, 2, each read before its channel;
  - writes {11, 11, 9, 9, 110, 110};
  - exactly 9 reads.
- **Backpressure.** Same stimulus as the basic case with random 0–5 cycle delays on `rready` and `wready`. Required: identical written data; `raddr`/`waddr`/`wdata` never change while their valid is high and unacknowledged.
- **Degenerate dimensions.** H=0 with `start`. Required: `done` at T+1, no `rvalid`/`wvalid` ever. Extra `start` pulses during a run are ignored.
- **Reset mid-run.** Pull `rst_n` low during element 2 of the basic case. Required: all outputs 0 immediately. After release, a new `start` rereads the bias and completes normally.
